// File: rtl/jm_host_mem_responder_pkg.sv
// Shared types for the host memory responder:
// channel FSM states and AXI response codes.
package jm_host_mem_responder_pkg;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/jm_resp_ram.sv
// Word-wide RAM with per-byte write enables,
// one write port and one registered read port.
module jm_resp_ram #(
  parameter int DATA_WIDTH = 1024,
  parameter int AWIDTH     = 6
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [AWIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [AWIDTH-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**AWIDTH];

  // Read-first: the read samples the old word even
  // when the same word is written on this edge.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/jm_host_mem_responder.sv
// AXI slave answering host reads and writes from a
// local RAM; independent read and write channel FSMs.
module jm_host_mem_responder
  import jm_host_mem_responder_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_AWIDTH = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam logic [MEM_AWIDTH-1:0] IDX_ONE = 1;

  // Address bits outside the word index are ignored.
  logic unused_addr;
  assign unused_addr = ^{s_axi_araddr, s_axi_awaddr};

  logic [MEM_AWIDTH-1:0] ar_idx;
  logic [MEM_AWIDTH-1:0] aw_idx;
  assign ar_idx = s_axi_araddr[MEM_AWIDTH+OFF-1:OFF];
  assign aw_idx = s_axi_awaddr[MEM_AWIDTH+OFF-1:OFF];

  // ---------------- read channel ----------------
  r_state_t              r_state;
  r_state_t              r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [MEM_AWIDTH-1:0] r_ptr;
  logic                  r_last;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  ram_re;
  logic [MEM_AWIDTH-1:0] ram_raddr;

  assign r_last = (r_beat == r_len);
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign r_hs   = s_axi_rvalid && s_axi_rready;

  // Read state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  // Read next state, handshake outputs and RAM fetch.
  // The next beat is fetched on the accepting edge so
  // rdata holds while the host stalls.
  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    ram_re        = 1'b0;
    ram_raddr     = r_ptr + IDX_ONE;
    unique case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          r_next    = R_BURST;
          ram_re    = 1'b1;
          ram_raddr = ar_idx;
        end
      end
      R_BURST: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          if (r_last) begin
            r_next = R_IDLE;
          end else begin
            ram_re = 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_id   <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_ptr  <= '0;
    end else if (ar_hs) begin
      r_id   <= s_axi_arid;
      r_len  <= s_axi_arlen;
      r_beat <= '0;
      r_ptr  <= ar_idx;
    end else if (r_hs && !r_last) begin
      r_beat <= r_beat + 8'd1;
      r_ptr  <= r_ptr + IDX_ONE;
    end
  end

  assign s_axi_rid   = r_id;
  assign s_axi_rresp = RESP_OKAY;
  assign s_axi_rlast = s_axi_rvalid && r_last;

  // ---------------- write channel ----------------
  w_state_t              w_state;
  w_state_t              w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [7:0]            w_len;
  logic [7:0]            w_beat;
  logic [MEM_AWIDTH-1:0] w_ptr;
  logic                  w_err;
  logic [1:0]            w_resp;
  logic                  w_end;
  logic                  aw_hs;
  logic                  w_hs;

  assign w_end = (w_beat == w_len);
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  // Write state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_next;
    end
  end

  // Write next state and handshake outputs.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          w_next = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_end) begin
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst bookkeeping; a wlast on the wrong beat,
  // or missing on the final one, turns into SLVERR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_id   <= '0;
      w_len  <= '0;
      w_beat <= '0;
      w_ptr  <= '0;
      w_err  <= 1'b0;
      w_resp <= RESP_OKAY;
    end else if (aw_hs) begin
      w_id   <= s_axi_awid;
      w_len  <= s_axi_awlen;
      w_beat <= '0;
      w_ptr  <= aw_idx;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      if (w_end) begin
        w_resp <= (w_err || !s_axi_wlast) ?
                  RESP_SLVERR : RESP_OKAY;
      end else begin
        w_err  <= w_err | s_axi_wlast;
        w_beat <= w_beat + 8'd1;
        w_ptr  <= w_ptr + IDX_ONE;
      end
    end
  end

  assign s_axi_bid   = w_id;
  assign s_axi_bresp = w_resp;

  // ---------------- storage ----------------
  jm_resp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .AWIDTH     (MEM_AWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_hs),
    .be    (s_axi_wstrb),
    .waddr (w_ptr),
    .wdata (s_axi_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (s_axi_rdata)
  );

endmodule

// File: tb/tb_jm_host_mem_responder.sv
// Directed bench for jm_host_mem_responder:
// bursts, strobes, wlast errors, wrap, stall, reset.
module tb_jm_host_mem_responder;

  localparam int DW = 1024;

  logic          clk;
  logic          resetn;
  logic [0:0]    arid;
  logic [63:0]   araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready;
  logic [0:0]    rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic [0:0]    awid;
  logic [63:0]   awaddr;
  logic [7:0]    awlen;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [127:0]  wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [0:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  int passed = 0;
  int total  = 0;

  localparam logic [DW-1:0] DA = {32{32'hA0A0_1234}};
  localparam logic [DW-1:0] DB = {32{32'hB1B1_5678}};
  localparam logic [DW-1:0] DC = {32{32'hC2C2_9ABC}};
  localparam logic [DW-1:0] DD = {32{32'hD3D3_DEF0}};
  localparam logic [DW-1:0] DE = {32{32'hE4E4_0F0F}};
  localparam logic [DW-1:0] DF = {32{32'hF5F5_7070}};
  localparam logic [127:0]  ALL = {128{1'b1}};

  jm_host_mem_responder dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h required %h (low 64b)",
                tag, obs[63:0], exp[63:0]);
  endtask

  task automatic axi_write(input string tag,
                           input logic [63:0] addr,
                           input logic [7:0] len,
                           input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1,
                           input logic [127:0] strb,
                           input int lastbeat,
                           input logic id,
                           input logic [1:0] exp_resp);
    awaddr  = addr;
    awlen   = len;
    awid    = id;
    awvalid = 1'b1;
    chk({tag, "_awready"}, awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wdata  = (i == 0) ? d0 : d1;
      wstrb  = strb;
      wlast  = (i == lastbeat);
      chk({tag, "_wready"}, wready, 1);
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bresp"}, bresp, exp_resp);
    chk({tag, "_bid"}, bid, id);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_awready_after"}, awready, 1);
  endtask

  task automatic axi_read(input string tag,
                          input logic [63:0] addr,
                          input logic [7:0] len,
                          input logic id,
                          input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1);
    araddr  = addr;
    arlen   = len;
    arid    = id;
    arvalid = 1'b1;
    chk({tag, "_arready"}, arready, 1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      chk({tag, "_rvalid"}, rvalid, 1);
      chk({tag, "_rdata"}, rdata, (i == 0) ? d0 : d1);
      chk({tag, "_rlast"}, rlast, (i == int'(len)) ? 1 : 0);
      chk({tag, "_rid"}, rid, id);
      chk({tag, "_rresp"}, rresp, 0);
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    chk({tag, "_rvalid_after"}, rvalid, 0);
    chk({tag, "_arready_after"}, arready, 1);
  endtask

  initial begin
    logic [DW-1:0] wd;
    logic [DW-1:0] ex;
    resetn  = 1'b0;
    arid    = '0;
    araddr  = '0;
    arlen   = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awid    = '0;
    awaddr  = '0;
    awlen   = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    tick();
    tick();

    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    resetn = 1'b1;
    tick();

    // Two-beat burst at index 1, read back.
    axi_write("w_ab", 64'h80, 8'd1, DA, DB, ALL, 1, 1'b1, 2'd0);
    axi_read("r_ab", 64'h80, 8'd1, 1'b1, DA, DB);

    // Single-byte strobe into a zeroed word.
    axi_write("w_z3", 64'h180, 8'd0, '0, '0, ALL, 0, 1'b0, 2'd0);
    wd = '1;
    wd[7:0] = 8'h5A;
    axi_write("w_b3", 64'h180, 8'd0, wd, '0, 128'h1, 0, 1'b0, 2'd0);
    ex = '0;
    ex[7:0] = 8'h5A;
    axi_read("r_b3", 64'h180, 8'd0, 1'b0, ex, '0);

    // Early wlast gives SLVERR.
    axi_write("w_early", 64'h380, 8'd1, DE, DF, ALL, 0, 1'b1, 2'd2);

    // Burst wrapping from index 63 to 0.
    axi_write("w_wrap", 64'h1F80, 8'd1, DC, DD, ALL, 1, 1'b0, 2'd0);
    axi_read("r_wrap", 64'h1F80, 8'd1, 1'b0, DC, DD);
    axi_read("r_idx0", 64'h0, 8'd0, 1'b1, DD, '0);

    // Same-edge read and write of index 5 returns old word.
    axi_write("w_e5", 64'h280, 8'd0, DE, '0, ALL, 0, 1'b0, 2'd0);
    awaddr  = 64'h280;
    awlen   = 8'd0;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata   = DF;
    wstrb   = ALL;
    wlast   = 1'b1;
    wvalid  = 1'b1;
    araddr  = 64'h280;
    arlen   = 8'd0;
    arid    = 1'b1;
    arvalid = 1'b1;
    tick();
    wvalid  = 1'b0;
    wlast   = 1'b0;
    arvalid = 1'b0;
    chk("rf_rvalid", rvalid, 1);
    chk("rf_rdata_old", rdata, DE);
    chk("rf_rlast", rlast, 1);
    chk("rf_bvalid", bvalid, 1);
    chk("rf_bresp", bresp, 0);
    rready = 1'b1;
    bready = 1'b1;
    tick();
    rready = 1'b0;
    bready = 1'b0;
    axi_read("r_f5", 64'h280, 8'd0, 1'b0, DF, '0);

    // Stall a three-beat burst, then reset mid-burst.
    araddr  = 64'h80;
    arlen   = 8'd2;
    arid    = 1'b1;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rdata", rdata, DA);
      chk("stall_rlast", rlast, 0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("beat2_rdata", rdata, DB);
    chk("beat2_rlast", rlast, 0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_arready", arready, 1);
    chk("mid_rst_rlast", rlast, 0);
    chk("mid_rst_rid", rid, 0);
    #2;
    resetn = 1'b1;
    tick();
    chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_bvalid", bvalid, 0);
    axi_read("r_keep", 64'h80, 8'd0, 1'b0, DA, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
